fld_extract: RTL and testbench

- Partial-field extractor, upstream of the compare stage.
- Takes a MIX word (sign + 5 six-bit bytes) and an F-spec (L:R); produces the field right-aligned, with a '+' sign unless L=0.
- Feeds in1/in2 of the compare unit (CMPx, 56-63) and the load path.
- Multi-cycle: shifts one byte per clock, then masks; start/stop handshake matches the other command units.

---
 rtl/mix_pkg.sv | 37 +++
 rtl/fld_extract_if.sv | 27 ++
 rtl/fld_mask.sv | 19 +
 rtl/fld_extract.sv | 134 +++++++++++++
 tb/tb_fld_extract.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/mix_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mix_pkg : shared MIX word constants, F-spec decode, FSM encoding |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package mix_pkg;

  localparam int BYTE_W   = 6;
  localparam int NBYTES   = 5;
  localparam int SIGN_BIT = 30;
  localparam int WORD_W   = 31;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  function automatic logic [2:0] fspec_l(input logic [5:0] f);
    return f[5:3];
  endfunction

  function automatic logic [2:0] fspec_r(input logic [5:0] f);
    return f[2:0];
  endfunction

  function automatic logic fspec_valid(input logic [5:0] f);
    return (fspec_r(f) <= 3'(NBYTES)) && (fspec_l(f) <= fspec_r(f));
  endfunction

  // Bytes kept after right-alignment; L=0 behaves as L=1 for the magnitude.
  function automatic logic [2:0] fspec_k(input logic [5:0] f);
    logic [2:0] lo;
    lo = (fspec_l(f) == 3'd0) ? 3'd1 : fspec_l(f);
    return fspec_r(f) - lo + 3'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fld_extract_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fld_extract_if : start/stop command bus of the field extractor   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface fld_extract_if #(
  parameter int WORD_W = mix_pkg::WORD_W
);
  logic              start;
  logic [WORD_W-1:0] in;
  logic [5:0]        field;
  logic              stop;
  logic              busy;
  logic [WORD_W-1:0] out;
  logic              error;

  modport master (
    output start, in, field,
    input  stop, busy, out, error
  );

  modport slave (
    input  start, in, field,
    output stop, busy, out, error
  );
endinterface
`default_nettype wire

// File: rtl/fld_mask.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fld_mask : byte mask keeping the low k bytes of a MIX magnitude  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module fld_mask #(
  parameter int BYTE_W = mix_pkg::BYTE_W,
  parameter int NBYTES = mix_pkg::NBYTES
) (
  input  logic [2:0]               k,
  output logic [BYTE_W*NBYTES-1:0] mask
);

  for (genvar b = 0; b < NBYTES; b++) begin : g_byte
    assign mask[b*BYTE_W +: BYTE_W] = {BYTE_W{(3'(b) < k)}};
  end

endmodule
`default_nettype wire

// File: rtl/fld_extract.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fld_extract : multi-cycle partial-field extractor (L:R of a word)|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module fld_extract #(
  parameter int BYTE_W = mix_pkg::BYTE_W,
  parameter int NBYTES = mix_pkg::NBYTES
) (
  input  logic         clk,
  input  logic         reset,
  fld_extract_if.slave bus
);
  import mix_pkg::*;

  localparam int MAG_W = BYTE_W * NBYTES;

  logic [1:0]       state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [2:0]       k_q, k_d;
  logic             sign_q, sign_d;
  logic [MAG_W-1:0] mag_q, mag_d;
  logic             stop_q, stop_d;
  logic             busy_q, busy_d;
  logic [MAG_W:0]   out_q, out_d;
  logic             error_q, error_d;
  logic [MAG_W-1:0] mask;

  fld_mask #(
    .BYTE_W (BYTE_W),
    .NBYTES (NBYTES)
  ) u_mask (
    .k    (k_q),
    .mask (mask)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      sign_q  <= 1'b0;
      mag_q   <= '0;
      stop_q  <= 1'b0;
      busy_q  <= 1'b0;
      out_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      stop_q  <= stop_d;
      busy_q  <= busy_d;
      out_q   <= out_d;
      error_q <= error_d;
    end
  end

  // DONE is left once stop has been shown for its single cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = fspec_valid(bus.field) ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == 3'd0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (stop_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // An invalid F-spec spends one DONE cycle with stop low, so it completes
  // with the same one-cycle latency as a (x:5) extraction.
  always_comb begin
    cnt_d   = cnt_q;
    k_d     = k_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    stop_d  = 1'b0;
    busy_d  = busy_q;
    out_d   = out_q;
    error_d = error_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          sign_d = bus.in[SIGN_BIT] & (fspec_l(bus.field) == 3'd0);
          mag_d  = bus.in[MAG_W-1:0];
          k_d    = fspec_k(bus.field);
          cnt_d  = 3'(NBYTES) - fspec_r(bus.field);
          busy_d = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (cnt_q != 3'd0) begin
          mag_d = mag_q >> BYTE_W;
          cnt_d = cnt_q - 3'd1;
        end else begin
          out_d   = {sign_q, mag_q & mask};
          error_d = 1'b0;
          stop_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      ST_DONE: begin
        if (!stop_q) begin
          out_d   = '0;
          error_d = 1'b1;
          stop_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign bus.stop  = stop_q;
  assign bus.busy  = busy_q;
  assign bus.out   = out_q;
  assign bus.error = error_q;

endmodule
`default_nettype wire

// File: tb/tb_fld_extract.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_fld_extract : scoreboard bench for the partial-field extractor|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_fld_extract;

  typedef struct {
    logic [30:0] out;
    logic        err;
    int          lat;
    int          cyc0;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_cmp;
  int   n_err;
  exp_t sb_q[$];
  exp_t mon_e;

  localparam logic [30:0] W = 31'h41083105;

  fld_extract_if bus_if ();

  fld_extract u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: concatenate bytes max(L,1)..R, byte i living at in[(5-i)*6 +: 6].
  function automatic void model(input logic [30:0] w, input logic [5:0] f,
                                output logic [30:0] o, output logic e, output int lat);
    int l;
    int r;
    int lo;
    logic [29:0] m;
    l = int'(f[5:3]);
    r = int'(f[2:0]);
    if (r > 5 || l > r) begin
      o = '0; e = 1'b1; lat = 1;
      return;
    end
    lo = (l == 0) ? 1 : l;
    m  = '0;
    for (int i = lo; i <= r; i++) m = (m << 6) | 30'(w[(5-i)*6 +: 6]);
    o   = {(l == 0) ? w[30] : 1'b0, m};
    e   = 1'b0;
    lat = 6 - r;
  endfunction

  task automatic run_job(input logic [30:0] w, input logic [5:0] f, input bit expect_accept);
    exp_t e;
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.in    = w;
    bus_if.field = f;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    bus_if.in    = 31'($urandom);
    bus_if.field = 6'($urandom);
    if (expect_accept) begin
      model(w, f, e.out, e.err, e.lat);
      e.cyc0 = cyc;
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      check_eq("drain_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_stop();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_if.stop && n < 20);
    if (!bus_if.stop) check_eq("stop_timeout", 32'(bus_if.stop), 32'd1);
  endtask

  always @(negedge clk) begin
    if (!reset && bus_if.stop) begin
      if (sb_q.size() == 0) begin
        check_eq("spurious_stop", 32'(bus_if.stop), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check_eq("out", 32'(bus_if.out), 32'(mon_e.out));
        check_eq("error", 32'(bus_if.error), 32'(mon_e.err));
        check_eq("latency", 32'(cyc - mon_e.cyc0), 32'(mon_e.lat));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc          = 0;
    n_cmp        = 0;
    n_err        = 0;
    reset        = 1'b1;
    bus_if.start = 1'b0;
    bus_if.in    = '0;
    bus_if.field = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_stop", 32'(bus_if.stop), 32'd0);
    check_eq("rst_busy", 32'(bus_if.busy), 32'd0);
    check_eq("rst_out", 32'(bus_if.out), 32'd0);
    check_eq("rst_error", 32'(bus_if.error), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Listed cases: (1:5), (1:3), (4:4), (0:0), then two invalid specs.
    run_job(W, 6'd13, 1'b1); wait_drain();
    run_job(W, 6'd11, 1'b1); wait_drain();
    run_job(W, 6'd36, 1'b1); wait_drain();
    run_job(W, 6'd0,  1'b1); wait_drain();
    run_job(W, 6'd25, 1'b1); wait_drain();
    run_job(W, 6'd7,  1'b1); wait_drain();

    // Second start while busy is dropped.
    run_job(W, 6'd0, 1'b1);
    @(negedge clk);
    check_eq("busy_mid", 32'(bus_if.busy), 32'd1);
    run_job(31'h12345678, 6'd13, 1'b0);
    wait_drain();

    // Start during the stop cycle is ignored; the next cycle is accepted.
    run_job(31'h3FFFFFFF, 6'd13, 1'b1);
    wait_stop();
    bus_if.start = 1'b1;
    bus_if.in    = 31'h7FFFFFFF;
    bus_if.field = 6'd5;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    run_job(31'h0ABCDEF1, 6'd36, 1'b1);
    wait_drain();

    // Reset in the middle of a job discards it.
    run_job(W, 6'd0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("midrst_stop", 32'(bus_if.stop), 32'd0);
    check_eq("midrst_busy", 32'(bus_if.busy), 32'd0);
    check_eq("midrst_out", 32'(bus_if.out), 32'd0);
    check_eq("midrst_error", 32'(bus_if.error), 32'd0);

    for (int i = 0; i < 16; i++) begin
      run_job(31'($urandom), 6'($urandom), 1'b1);
      wait_drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
